// File: rtl/fetch_sequencer.sv
// Program counter, instruction register and return stack for the DE0 MCU fetch path.
// GOTO/CALL/RETURN/RETFIE/RETLW resolve here with a one-bubble penalty.
module fetch_sequencer #(
    parameter int unsigned STACK_DEPTH  = 8,
    parameter logic [10:0] RESET_VECTOR = 11'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] Rom_addr_out,
    input  logic [13:0] Rom_data_in,
    input  logic        stall,
    input  logic        skip,
    output logic [13:0] ir_out,
    output logic        ir_valid,
    output logic [3:0]  stack_depth,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        CF_NONE,
        CF_GOTO,
        CF_CALL,
        CF_RET
    } cf_e;

    logic [10:0]      pc_q, pc_d;
    logic [13:0]      ir_q, ir_d;
    logic             irv_q, irv_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rd_ptr;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [10:0]      stack_q [STACK_DEPTH];
    cf_e              cf;

    always_comb begin
        cf = CF_NONE;
        if (irv_q) begin
            if (ir_q[13:11] == 3'b101) begin
                cf = CF_GOTO;
            end else if (ir_q[13:11] == 3'b100) begin
                cf = CF_CALL;
            end else if (ir_q == 14'h0008 || ir_q == 14'h0009 || ir_q[13:10] == 4'b1101) begin
                cf = CF_RET;
            end
        end
    end

    // Pops move the pointer even at depth 0, so underflow reads keep walking the ring.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        wptr_d  = wptr_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        rd_ptr  = wptr_q - PTR_W'(1);
        if (!stall) begin
            case (cf)
                CF_GOTO: begin
                    pc_d  = ir_q[10:0];
                    ir_d  = '0;
                    irv_d = 1'b0;
                end
                CF_CALL: begin
                    pc_d   = ir_q[10:0];
                    ir_d   = '0;
                    irv_d  = 1'b0;
                    push   = 1'b1;
                    wptr_d = wptr_q + PTR_W'(1);
                    if (depth_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        depth_d = depth_q + CNT_W'(1);
                    end
                end
                CF_RET: begin
                    pc_d   = stack_q[rd_ptr];
                    ir_d   = '0;
                    irv_d  = 1'b0;
                    wptr_d = rd_ptr;
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        depth_d = depth_q - CNT_W'(1);
                    end
                end
                default: begin
                    pc_d  = pc_q + 11'd1;
                    ir_d  = Rom_data_in;
                    irv_d = !skip;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            wptr_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            wptr_q  <= wptr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push) begin
            stack_q[wptr_q] <= pc_q;
        end
    end

    assign Rom_addr_out    = pc_q;
    assign ir_out          = ir_q;
    assign ir_valid        = irv_q;
    assign stack_depth     = 4'(depth_q);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model queues expected state per edge,
// a monitor compares it after each rising edge; directed checks cover the documented scenarios.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, skip;
    logic [10:0] addr;
    logic [13:0] rom_data, ir_out;
    logic        ir_valid, ovf, unf;
    logic [3:0]  depth;
    logic [13:0] rom [2048];

    assign rom_data = rom[addr];

    fetch_sequencer #(.STACK_DEPTH(8), .RESET_VECTOR(11'h000)) dut (
        .clk(clk), .reset(reset), .Rom_addr_out(addr), .Rom_data_in(rom_data),
        .stall(stall), .skip(skip), .ir_out(ir_out), .ir_valid(ir_valid),
        .stack_depth(depth), .stack_overflow(ovf), .stack_underflow(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] pc;
        logic [13:0] ir;
        logic        irv;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: PC, IR, a ring of 8 return addresses with a pointer and a depth count.
    int m_pc, m_ir, m_irv, m_wp, m_depth, m_ovf, m_unf;
    int m_stk [8];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge(input bit rst, input bit st, input bit sk);
        if (rst) begin
            m_pc = 0; m_ir = 0; m_irv = 0; m_wp = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
            for (int i = 0; i < 8; i++) m_stk[i] = 0;
        end else if (!st) begin
            if (m_irv == 1 && (m_ir >> 11) == 5) begin
                m_pc = m_ir % 2048; m_ir = 0; m_irv = 0;
            end else if (m_irv == 1 && (m_ir >> 11) == 4) begin
                m_stk[m_wp] = m_pc;
                m_wp = (m_wp + 1) % 8;
                if (m_depth == 8) m_ovf = 1; else m_depth++;
                m_pc = m_ir % 2048; m_ir = 0; m_irv = 0;
            end else if (m_irv == 1 && (m_ir == 8 || m_ir == 9 || (m_ir >> 10) == 13)) begin
                m_wp = (m_wp + 7) % 8;
                m_pc = m_stk[m_wp];
                if (m_depth == 0) m_unf = 1; else m_depth--;
                m_ir = 0; m_irv = 0;
            end else begin
                m_ir  = int'(rom[m_pc]);
                m_pc  = (m_pc + 1) % 2048;
                m_irv = sk ? 0 : 1;
            end
        end
    endtask

    task automatic step(input bit rst = 0, input bit st = 0, input bit sk = 0);
        exp_t e;
        reset = rst; stall = st; skip = sk;
        model_edge(rst, st, sk);
        e.pc = 11'(m_pc); e.ir = 14'(m_ir); e.irv = 1'(m_irv);
        e.depth = 4'(m_depth); e.ovf = 1'(m_ovf); e.unf = 1'(m_unf);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_ir(input logic [13:0] w, input int dep, input int maxc);
        bit found = 0;
        for (int i = 0; i < maxc && !found; i++) begin
            if (ir_valid === 1'b1 && ir_out === w && (dep < 0 || int'(depth) == dep)) found = 1;
            else step();
        end
        chk("wait_ir", 32'(found), 32'd1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_addr",  32'(addr),     32'(e.pc));
                chk("sb_ir",    32'(ir_out),   32'(e.ir));
                chk("sb_valid", 32'(ir_valid), 32'(e.irv));
                chk("sb_depth", 32'(depth),    32'(e.depth));
                chk("sb_ovf",   32'(ovf),      32'(e.ovf));
                chk("sb_unf",   32'(unf),      32'(e.unf));
            end
        end
    end

    initial begin : driver
        bit found;
        int k;
        reset = 1'b1; stall = 1'b0; skip = 1'b0;

        // Free run, CALL/RETURN, skip, GOTO
        clear_rom();
        rom[0] = 14'h3024; rom[1] = 14'h00A5; rom[4] = 14'h2010; rom[8] = 14'h0123;
        rom[11'h010] = 14'h0008; rom[11'h00B] = 14'h1FA6; rom[11'h00C] = 14'h2808;
        rom[11'h00D] = 14'h0ABC;
        step(1); step(1);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_ir", 32'(ir_out), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_flags", 32'({ovf, unf}), 32'h0);
        step();
        chk("run_ir0", 32'(ir_out), 32'h3024);
        chk("run_v0", 32'(ir_valid), 32'h1);
        chk("run_addr1", 32'(addr), 32'h1);
        step();
        chk("run_ir1", 32'(ir_out), 32'h00A5);
        chk("run_addr2", 32'(addr), 32'h2);
        wait_ir(14'h2010, -1, 20);
        step();
        chk("call_depth", 32'(depth), 32'h1);
        chk("call_pc", 32'(addr), 32'h010);
        chk("call_bubble", 32'(ir_valid), 32'h0);
        step();
        chk("ret_in_ir", 32'(ir_out), 32'h0008);
        step();
        chk("ret_pc", 32'(addr), 32'h005);
        chk("ret_depth", 32'(depth), 32'h0);
        chk("ret_bubble", 32'(ir_valid), 32'h0);
        wait_ir(14'h1FA6, -1, 20);
        step(0, 0, 1);
        chk("skip_bubble", 32'(ir_valid), 32'h0);
        chk("skip_addr", 32'(addr), 32'h00D);
        step();
        chk("skip_ir", 32'(ir_out), 32'h0ABC);
        chk("skip_valid", 32'(ir_valid), 32'h1);
        chk("skip_nojump", 32'(addr), 32'h00E);
        step(1);
        wait_ir(14'h2808, -1, 40);
        step();
        chk("goto_pc", 32'(addr), 32'h008);
        chk("goto_bubble", 32'(ir_valid), 32'h0);
        step();
        chk("goto_ir", 32'(ir_out), 32'h0123);
        chk("goto_addr", 32'(addr), 32'h009);

        // Nine nested CALLs then RETURNs
        clear_rom();
        rom[0] = 14'h2900;
        for (int i = 0; i < 9; i++) begin
            rom[11'h100 + 11'(16 * i)]     = 14'h2000 | 14'(11'h100 + 11'(16 * (i + 1)));
            rom[11'h100 + 11'(16 * i) + 1] = 14'h0008;
        end
        rom[11'h190] = 14'h0008;
        step(1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ovf === 1'b1) found = 1; else step();
        end
        chk("ovf_seen", 32'(found), 32'h1);
        chk("ovf_depth", 32'(depth), 32'h8);
        chk("ovf_pc", 32'(addr), 32'h190);
        wait_ir(14'h0008, 1, 100);
        step();
        chk("ret8_pc", 32'(addr), 32'h111);
        chk("ret8_depth", 32'(depth), 32'h0);
        chk("ret8_unf", 32'(unf), 32'h0);
        wait_ir(14'h0008, -1, 10);
        step();
        chk("ret9_unf", 32'(unf), 32'h1);
        chk("ret9_depth", 32'(depth), 32'h0);
        chk("ret9_pc", 32'(addr), 32'h181);

        // Stall on CALL, reset over RETURN
        clear_rom();
        rom[0] = 14'h2020; rom[11'h020] = 14'h0008;
        step(1);
        step();
        chk("st_ir", 32'(ir_out), 32'h2020);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1);
            chk("st_hold_pc", 32'(addr), 32'h001);
            chk("st_hold_ir", 32'(ir_out), 32'h2020);
            chk("st_hold_v", 32'(ir_valid), 32'h1);
            chk("st_hold_depth", 32'(depth), 32'h0);
        end
        step();
        chk("st_call_pc", 32'(addr), 32'h020);
        chk("st_call_depth", 32'(depth), 32'h1);
        step();
        chk("st_ret_ir", 32'(ir_out), 32'h0008);
        step(1);
        chk("rr_pc", 32'(addr), 32'h0);
        chk("rr_depth", 32'(depth), 32'h0);
        chk("rr_valid", 32'(ir_valid), 32'h0);

        // PC wrap
        clear_rom();
        rom[0] = 14'h2FFE; rom[11'h7FE] = 14'h0123; rom[11'h7FF] = 14'h0456;
        step(1); step(); step();
        chk("wrap_goto", 32'(addr), 32'h7FE);
        step();
        chk("wrap_7ff", 32'(addr), 32'h7FF);
        step();
        chk("wrap_ir", 32'(ir_out), 32'h0456);
        chk("wrap_zero", 32'(addr), 32'h000);
        step();
        chk("wrap_next", 32'(ir_out), 32'h2FFE);

        // Random program with random stall/skip/reset
        for (int i = 0; i < 2048; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0: rom[i] = 14'h2800 | 14'($urandom_range(0, 2047));
                1: rom[i] = 14'h2000 | 14'($urandom_range(0, 2047));
                2: rom[i] = 14'h0008;
                3: rom[i] = 14'h0009;
                4: rom[i] = 14'h3400 | 14'($urandom_range(0, 255));
                default: rom[i] = 14'($urandom_range(0, 16383));
            endcase
        end
        step(1);
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            step(k < 1, k >= 1 && k < 16, $urandom_range(0, 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

- Program-counter and fetch controller that sequences the 14-bit-wide, 2K-word program ROM of the DE0 MCU.
- Drives the ROM address and registers the returned word into an instruction register (IR) for the execute stage.
- Resolves GOTO, CALL, RETURN, RETLW and RETFIE locally using an 8-level hardware return stack.
- Applies skip squashes and stalls requested by the datapath.

## Interface

Parameters:
- STACK_DEPTH, 8: number of return-stack entries (power of two).
- RESET_VECTOR, 11'h000: PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Rom_addr_out  out  11  ROM word address; equals the PC register.
- Rom_data_in  in  14  ROM word at Rom_addr_out (combinational ROM, same cycle).
- stall  in  1  hold all state (PC, IR, ir_valid, stack) this cycle.
- skip  in  1  datapath request: squash the word being fetched this cycle.
- ir_out  out  14  executing instruction.
- ir_valid  out  1  ir_out is a real instruction (0 = bubble, datapath treats it as NOP).
- stack_depth  out  4  current number of valid stack entries, 0..STACK_DEPTH.
- stack_overflow  out  1  sticky; set by a push at full depth.
- stack_underflow  out  1  sticky; set by a pop at zero depth.

## Operation

- Two stages:
  - Fetch: PC addresses the ROM.
  - Execute: the IR holds the previously fetched word.
- Control flow is decoded from IR, and only when ir_valid=1:
  - GOTO: IR[13:11]=3'b101; target = IR[10:0].
  - CALL: IR[13:11]=3'b100; target = IR[10:0]; push PC, which already holds the call address + 1.
  - RETURN = 14'h0008 and RETFIE = 14'h0009: pop; target = popped entry.
  - RETLW: IR[13:10]=4'b1101: pop; target = popped entry. W is loaded by the datapath from IR[7:0].
- Per-cycle priority, highest first:
  1. reset
  2. stall
  3. control flow in IR: PC <= target, IR <= 0, ir_valid <= 0. The word fetched this cycle is discarded.
  4. skip: PC <= PC+1, IR <= Rom_data_in, ir_valid <= 0.
  5. sequential: PC <= PC+1, IR <= Rom_data_in, ir_valid <= 1.
- A skip asserted together with a control-flow IR is ignored.
- PC arithmetic is 11-bit modulo: 11'h7FF + 1 = 11'h000.
- Stack is circular, with a write pointer and a depth counter.
- Push at depth = STACK_DEPTH:
  - overwrites the oldest entry (pointer wraps);
  - depth stays at STACK_DEPTH;
  - stack_overflow <= 1.
- Pop at depth = 0:
  - returns the entry at pointer-1 (wrapped);
  - depth stays 0;
  - stack_underflow <= 1;
  - the jump still occurs.
- Sticky flags clear only on reset.

## Timing

- Reset values:
  - PC = RESET_VECTOR, so Rom_addr_out = RESET_VECTOR.
  - ir_out = 14'h0000, ir_valid = 0.
  - stack_depth = 0, both flags = 0.
  - Stack contents are don't-care.
- First edge after reset deasserts: IR = ROM[RESET_VECTOR], ir_valid = 1.
- Sequential throughput: one instruction per cycle.
- Control-flow penalty: exactly one bubble cycle (ir_valid=0). The target word is in IR two edges after the control-flow word enters IR.
- Skip penalty: one bubble, which replaces the skipped word.
- Stall:
  - Holds PC, IR, ir_valid and stack for every cycle it is high.
  - A control-flow IR held under stall resolves on the first unstalled edge.
  - skip is ignored while stalled.
- Reset mid-operation (pending CALL/RETURN, stall or skip high): reset wins on that edge. No push or pop occurs.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset, then free-run with ROM[0]=14'h3024, ROM[1]=14'h00A5:
  - Rom_addr_out goes 0,1,2.
  - ir_out=14'h3024 with ir_valid=1 after first edge, 14'h00A5 after second.
- GOTO: ROM[0xC]=14'h2808:
  - Cycle after IR=14'h2808: Rom_addr_out=0x008 and ir_valid=0.
  - Next cycle: ir_out=ROM[8], Rom_addr_out=0x009.
- CALL/RETURN: ROM[0x4]=14'h2010, ROM[0x10]=14'h0008:
  - After CALL: stack_depth=1, PC=0x010.
  - After RETURN: PC=0x005, stack_depth=0.
  - Each transfer shows one bubble.
- Skip:
  - Hold skip=1 for one cycle while IR=14'h1FA6 from address 0xB.
  - Required: word 0xC is squashed (ir_valid=0), then ir_out=ROM[0xD] with ir_valid=1. No jump to 8.
- Stack limits:
  - Nine nested CALLs: stack_overflow=1, stack_depth=8.
  - Nine RETURNs: the eighth returns the second call's return address; the ninth sets stack_underflow=1; depth=0.
- Stall and reset:
  - stall=1 for 3 cycles with a CALL in IR: PC, IR and depth are unchanged, then the CALL resolves.
  - reset asserted while RETURN is in IR: PC=0, depth=0, ir_valid=0.
  - PC wrap: sequential fetch at 0x7FF is followed by fetch at 0x000.
